// File: rtl/ram_prog_loader.sv
// Program RAM loader: streams a byte image into RAM from address 0, then reads
// it back and flags a mismatch between the write-side and read-side checksums.
module ram_prog_loader #(
  parameter int AW     = 6,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [AW-1:0] i_len,
  input  logic          i_s_valid,
  input  logic [DW-1:0] i_s_data,
  output logic          o_s_ready,
  output logic          o_ram_iwr,
  output logic          o_ram_edtb,
  output logic [AW-1:0] o_ram_addr,
  output logic [DW-1:0] o_ram_din,
  input  logic [DW-1:0] i_ram_dout,
  output logic          o_cpu_hold,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err,
  output logic [DW-1:0] o_checksum
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW:0]   r_n;
  logic [AW:0]   r_cnt;
  logic [AW:0]   r_iss;
  logic [AW:0]   r_smp;
  logic [RD_LAT:0] r_pipe;
  logic [DW-1:0] r_wr_sum;
  logic [DW-1:0] r_rd_sum;
  logic          r_iwr;
  logic          r_edtb;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_din;
  logic          r_err;
  logic          w_start_ok;
  logic          w_s_ready;
  logic          w_hs;
  logic          w_issue;
  logic          w_sample;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start_ok  = 1'b0;
    w_s_ready   = 1'b0;
    w_hs        = 1'b0;
    w_issue     = 1'b0;
    w_sample    = r_pipe[RD_LAT];
    case (r_state)
      S_IDLE, S_DONE: begin
        w_start_ok = i_start;
        if (i_start) w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        w_s_ready = (r_cnt < r_n);
        w_hs      = w_s_ready & i_s_valid;
        if (r_cnt == r_n) w_state_nxt = S_READ;
      end
      S_READ: begin
        w_issue = (r_iss < r_n);
        if (r_smp == r_n) w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_n      <= '0;
      r_cnt    <= '0;
      r_iss    <= '0;
      r_smp    <= '0;
      r_pipe   <= '0;
      r_wr_sum <= '0;
      r_rd_sum <= '0;
      r_iwr    <= 1'b0;
      r_edtb   <= 1'b0;
      r_addr   <= '0;
      r_din    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_iwr <= w_hs;
      if (w_start_ok) begin
        // len of 0 encodes a full 2^AW image, hence the AW+1 bit counters
        r_n      <= (i_len == '0) ? {1'b1, {AW{1'b0}}} : {1'b0, i_len};
        r_cnt    <= '0;
        r_iss    <= '0;
        r_smp    <= '0;
        r_pipe   <= '0;
        r_wr_sum <= '0;
        r_rd_sum <= '0;
        r_err    <= 1'b0;
      end
      if (w_hs) begin
        r_addr   <= r_cnt[AW-1:0];
        r_din    <= i_s_data;
        r_wr_sum <= r_wr_sum + i_s_data;
        r_cnt    <= r_cnt + 1'b1;
      end
      if (r_state == S_WRITE && r_cnt == r_n) begin
        r_edtb <= 1'b1;
        r_addr <= '0;
        r_iss  <= {{AW{1'b0}}, 1'b1};
        r_pipe <= {{RD_LAT{1'b0}}, 1'b1};
      end
      if (r_state == S_READ) begin
        // r_pipe tags each presented address until its data is on i_ram_dout
        r_pipe <= {r_pipe[RD_LAT-1:0], w_issue};
        if (w_issue) begin
          r_addr <= r_iss[AW-1:0];
          r_iss  <= r_iss + 1'b1;
        end
        if (w_sample) begin
          r_rd_sum <= r_rd_sum + i_ram_dout;
          r_smp    <= r_smp + 1'b1;
        end
        if (r_smp == r_n) begin
          r_edtb <= 1'b0;
          r_err  <= (r_rd_sum != r_wr_sum);
        end
      end
    end
  end

  assign o_s_ready  = w_s_ready;
  assign o_ram_iwr  = r_iwr;
  assign o_ram_edtb = r_edtb;
  assign o_ram_addr = r_addr;
  assign o_ram_din  = r_din;
  assign o_busy     = (r_state == S_WRITE) || (r_state == S_READ);
  assign o_cpu_hold = o_busy;
  assign o_done     = (r_state == S_DONE);
  assign o_err      = r_err;
  assign o_checksum = r_wr_sum;

endmodule

// File: tb/tb_ram_prog_loader.sv
// Directed bench for ram_prog_loader with a behavioural synchronous-read RAM
// (one cycle read latency) that can corrupt address 3 on write.
module tb_ram_prog_loader;

  logic       clk = 1'b0;
  logic       i_rst, i_start, i_s_valid;
  logic [5:0] i_len;
  logic [7:0] i_s_data, i_ram_dout;
  logic       o_s_ready, o_ram_iwr, o_ram_edtb, o_cpu_hold, o_busy, o_done, o_err;
  logic [5:0] o_ram_addr;
  logic [7:0] o_ram_din, o_checksum;

  int errors = 0;
  int checks = 0;
  bit corrupt = 1'b0;
  logic [7:0] mem [64];

  always #5 clk = ~clk;

  ram_prog_loader #(.AW(6), .DW(8), .RD_LAT(1)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_len(i_len),
    .i_s_valid(i_s_valid), .i_s_data(i_s_data), .o_s_ready(o_s_ready),
    .o_ram_iwr(o_ram_iwr), .o_ram_edtb(o_ram_edtb), .o_ram_addr(o_ram_addr),
    .o_ram_din(o_ram_din), .i_ram_dout(i_ram_dout), .o_cpu_hold(o_cpu_hold),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_checksum(o_checksum)
  );

  always @(posedge clk) begin
    if (o_ram_iwr) mem[o_ram_addr] <= (corrupt && o_ram_addr == 6'd3) ? o_ram_din + 8'd1 : o_ram_din;
    if (o_ram_edtb) i_ram_dout <= mem[o_ram_addr];
  end

  typedef struct packed {
    logic [5:0]      len;
    logic [0:7][7:0] data;
    logic            ramp;
    logic            gap;
    logic            corrupt;
    logic            poke;
    logic [7:0]      exp_sum;
    logic            exp_err;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_s_ready"}, 32'(o_s_ready), 0);
    chk({nm, "_iwr"}, 32'(o_ram_iwr), 0);
    chk({nm, "_edtb"}, 32'(o_ram_edtb), 0);
    chk({nm, "_addr"}, 32'(o_ram_addr), 0);
    chk({nm, "_din"}, 32'(o_ram_din), 0);
    chk({nm, "_hold"}, 32'(o_cpu_hold), 0);
    chk({nm, "_busy"}, 32'(o_busy), 0);
    chk({nm, "_done"}, 32'(o_done), 0);
    chk({nm, "_err"}, 32'(o_err), 0);
    chk({nm, "_checksum"}, 32'(o_checksum), 0);
  endtask

  task automatic run_load(input int id, input vec_t v);
    int n, acc, rd_exp, cyc;
    logic hs_prev, toggle, vld;
    logic [7:0] b, b_prev;
    n = (v.len == 6'd0) ? 64 : int'(v.len);
    corrupt = v.corrupt;
    acc = 0; rd_exp = 0; hs_prev = 1'b0; toggle = 1'b1; b_prev = 8'h00;
    @(negedge clk);
    i_len = v.len;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    cyc = 1;
    chk($sformatf("v%0d_busy_on", id), 32'(o_busy), 1);
    chk($sformatf("v%0d_done_clr", id), 32'(o_done), 0);
    chk($sformatf("v%0d_err_clr", id), 32'(o_err), 0);
    while (!o_done && cyc < 4 * n + 40) begin
      chk($sformatf("v%0d_c%0d_iwr", id, cyc), 32'(o_ram_iwr), 32'(hs_prev));
      if (hs_prev) begin
        chk($sformatf("v%0d_wr_addr%0d", id, acc - 1), 32'(o_ram_addr), 32'(acc - 1));
        chk($sformatf("v%0d_wr_din%0d", id, acc - 1), 32'(o_ram_din), 32'(b_prev));
      end
      chk($sformatf("v%0d_c%0d_hold", id, cyc), 32'(o_cpu_hold), 1);
      chk($sformatf("v%0d_c%0d_ready", id, cyc), 32'(o_s_ready), 32'(acc < n));
      if (o_ram_edtb) begin
        chk($sformatf("v%0d_rd_addr%0d", id, rd_exp), 32'(o_ram_addr), 32'(rd_exp));
        if (rd_exp < n - 1) rd_exp++;
      end
      if (v.poke && cyc == 3) begin
        i_start = 1'b1;
        i_len = 6'd1;
      end else begin
        i_start = 1'b0;
        i_len = v.len;
      end
      vld = v.gap ? toggle : 1'b1;
      toggle = ~toggle;
      b = v.ramp ? 8'(acc) : ((acc < 8) ? v.data[acc] : 8'h00);
      i_s_valid = vld;
      i_s_data = b;
      hs_prev = vld && (acc < n);
      if (hs_prev) begin
        b_prev = b;
        acc++;
      end
      @(negedge clk);
      cyc++;
    end
    i_s_valid = 1'b0;
    i_start = 1'b0;
    chk($sformatf("v%0d_done", id), 32'(o_done), 1);
    if (!v.gap) chk($sformatf("v%0d_latency", id), 32'(cyc), 32'(2 * n + 4));
    chk($sformatf("v%0d_swept", id), 32'(rd_exp), 32'(n - 1));
    chk($sformatf("v%0d_err", id), 32'(o_err), 32'(v.exp_err));
    chk($sformatf("v%0d_checksum", id), 32'(o_checksum), 32'(v.exp_sum));
    chk($sformatf("v%0d_busy_off", id), 32'(o_busy), 0);
    chk($sformatf("v%0d_hold_off", id), 32'(o_cpu_hold), 0);
    chk($sformatf("v%0d_edtb_off", id), 32'(o_ram_edtb), 0);
    i_s_valid = 1'b1;
    chk($sformatf("v%0d_done_ready", id), 32'(o_s_ready), 0);
    @(negedge clk);
    i_s_valid = 1'b0;
    chk($sformatf("v%0d_done_iwr", id), 32'(o_ram_iwr), 0);
    chk($sformatf("v%0d_done_sticky", id), 32'(o_done), 1);
    corrupt = 1'b0;
  endtask

  initial begin
    //               len    data bytes                                               ramp gap cor poke sum    err
    vecs[0] = '{6'd6, {8'h3e, 8'h06, 8'hc6, 8'h07, 8'h76, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b0, 1'b0, 1'b0, 8'h87, 1'b0};
    vecs[1] = '{6'd6, {8'h3e, 8'h06, 8'hc6, 8'h07, 8'h76, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b1, 1'b0, 1'b0, 8'h87, 1'b0};
    vecs[2] = '{6'd6, {8'h3e, 8'h06, 8'hc6, 8'h07, 8'h76, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b0, 1'b1, 1'b0, 8'h87, 1'b1};
    vecs[3] = '{6'd2, {8'h3e, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b0, 1'b0, 1'b0, 8'h44, 1'b0};
    vecs[4] = '{6'd0, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b1, 1'b0, 1'b0, 1'b0, 8'he0, 1'b0};
    vecs[5] = '{6'd6, {8'h3e, 8'h06, 8'hc6, 8'h07, 8'h76, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b0, 1'b0, 1'b1, 8'h87, 1'b0};

    i_rst = 1'b1; i_start = 1'b0; i_len = 6'd0; i_s_valid = 1'b0; i_s_data = 8'h00;
    repeat (2) @(negedge clk);
    check_zero("reset");
    i_rst = 1'b0;

    for (int i = 0; i < 4; i++) run_load(i, vecs[i]);

    // reset in the third WRITE cycle, together with a start pulse
    @(negedge clk);
    i_len = 6'd6;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_s_valid = 1'b1;
    i_s_data = 8'h3e;
    @(negedge clk);
    i_s_data = 8'h06;
    @(negedge clk);
    i_rst = 1'b1;
    i_start = 1'b1;
    @(negedge clk);
    check_zero("rst_mid");
    i_rst = 1'b0;
    i_start = 1'b0;
    i_s_valid = 1'b0;
    @(negedge clk);
    chk("rst_idle_busy", 32'(o_busy), 0);
    chk("rst_idle_done", 32'(o_done), 0);

    for (int i = 4; i < 6; i++) run_load(i, vecs[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_prog_loader.md
Name: ram_prog_loader

Overview:
- Initiator for the 6-bit-address / 8-bit-data program RAM port (iwr, addr, din, dout, EDTB).
- Accepts a program byte stream over a valid/ready handshake and writes it sequentially from address 0.
- Reads the written range back and compares an 8-bit additive checksum against the one accumulated during writing.
- Holds the CPU off the bus (cpu_hold) for the whole operation; sits between the host/byte-source and the RAM.

Parameters:
- AW, 6, RAM address width; max image = 2^AW bytes.
- DW, 8, data width.
- RD_LAT, 1, clock cycles from ram_addr applied (ram_edtb=1) to valid ram_dout.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load when idle or done.
- len  in  AW  image length in bytes, sampled on start; 0 means 2^AW.
- s_valid  in  1  byte-source data valid.
- s_data  in  DW  program byte.
- s_ready  out  1  loader accepts s_data this cycle.
- ram_iwr  out  1  RAM write enable.
- ram_edtb  out  1  RAM drive-to-bus enable for read-back.
- ram_addr  out  AW  RAM address.
- ram_din  out  DW  RAM write data.
- ram_dout  in  DW  RAM read data.
- cpu_hold  out  1  keeps CPU halted while loading.
- busy  out  1  operation in progress.
- done  out  1  load and verify complete (sticky).
- err  out  1  checksum mismatch (valid when done=1).
- checksum  out  DW  write-side checksum, sum of bytes mod 2^DW.

Behaviour:
- Reset (sync, rst=1 at edge): state IDLE; every output 0, including ram_addr and checksum.
- rst mid-operation: next edge returns to IDLE with ram_iwr=0 and cpu_hold=0; partial RAM contents are left as written.
- States: IDLE, WRITE, READ, DONE.
- IDLE / DONE:
  - start=1: latch N (len, or 2^AW if len=0); clear counters and both sums; done=0, err=0; busy=1, cpu_hold=1 → WRITE.
  - s_valid is ignored; s_ready=0.
- WRITE:
  - s_ready=1 while accepted count < N.
  - On s_valid&s_ready (handshake at edge k), registered outputs at edge k+1: ram_iwr=1, ram_addr=count, ram_din=s_data.
  - The same edge updates wr_sum += s_data (mod 256) and count+1.
  - ram_iwr is 1 only in cycles following a handshake; s_valid gaps give ram_iwr=0.
  - s_ready drops in the cycle after the Nth handshake.
  - After the Nth write pulse → READ.
- READ:
  - ram_iwr=0, ram_edtb=1.
  - ram_addr steps 0..N-1, one address per cycle.
  - Data for address a is sampled RD_LAT cycles after a is presented and added into rd_sum.
  - After the Nth sample: ram_edtb=0; err=(rd_sum!=wr_sum) → DONE.
- DONE: done=1, busy=0, cpu_hold=0; checksum=wr_sum is held until the next start or rst.
- start while busy=1 is ignored.
- Address wrap:
  - Counters are AW+1 bits so N=2^AW is handled.
  - ram_addr never exceeds 2^AW-1 and never wraps to 0 during one load.
- Simultaneous rst and start: rst wins.
- Total latency (no source stalls) from start to done: 1 + N + 1 + N + RD_LAT + 1 cycles.

Test Plan:
- Load 6 bytes with len=6, s_valid held high, stream 3e,06,c6,07,76,00 → writes at addr 0..5 on consecutive cycles; read-back sweeps 0..5; done=1, err=0, checksum=0x87; cpu_hold high throughout, then 0.
- Same image with s_valid toggling 1,0,1,0 → ram_iwr pulses only after handshakes; addresses stay contiguous 0..5; checksum=0x87, err=0.
- Model corrupts the RAM byte at addr 3 (07→08) before read-back → done=1, err=1, checksum=0x87.
- len=0, 64 bytes 0x00..0x3f → last write at addr 63 with no wrap; checksum=0xE0; err=0.
- rst asserted in the 3rd WRITE cycle → next edge all outputs 0, state IDLE; a start pulse during busy has no effect; a following start reloads correctly.
- start reissued in DONE → done and err clear on the next edge; the second load of 3e,06 gives checksum=0x44.
